// File: rtl/hf_14a_tag_frame_decoder.sv
// ISO14443-A tag->reader frame decoder at 106 kbit/s: Manchester halves, SOF/EOF, bytes, odd parity.
// Define HF14A_COLLISION_EN to report collisions on coll/coll_pos.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for the first modulated slot (slot 0 of SOF)
//  S_SOF  | collecting the SOF bit period; a clean '1' opens the frame
//  S_DATA | decoding data/parity bits until an unmodulated bit period (EOF)
`timescale 1ns/1ps

module hf_14a_tag_frame_decoder #(
    parameter int MOD_MIN = 2
) (
    input  logic       osc_clk,
    input  logic       nreset,
    input  logic       enable,
    input  logic       slot_strobe,
    input  logic       curbit,
    output logic       frame_active,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       parity_bit,
    output logic       parity_err,
    output logic       frame_end,
    output logic [2:0] last_bits,
    output logic       coll,
    output logic [6:0] coll_pos
);

    localparam logic [3:0] MOD_MIN_W = 4'(MOD_MIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SOF  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_ONE  = 2'd1,
        SYM_EOF  = 2'd2,
        SYM_COLL = 2'd3
    } sym_t;

    state_t     state_q, state_d;

    logic [2:0] slot_q;
    logic [2:0] cnt_a_q;
    logic [2:0] cnt_b_q;
    logic [7:0] shift_q;
    logic [7:0] tail_q;
    logic [3:0] grp_q;

    logic       frame_active_q;
    logic       byte_valid_q;
    logic [7:0] data_byte_q;
    logic       parity_bit_q;
    logic       parity_err_q;
    logic       frame_end_q;
    logic [2:0] last_bits_q;

    logic       strobe_ok;
    logic       bit_end;
    logic [3:0] b_sum;
    logic       a_mod;
    logic       b_mod;
    sym_t       sym;
    logic       data_bit;

    logic       sof_start;
    logic       sof_ok;
    logic       bit_take;
    logic       byte_done;
    logic       eof_done;

    // Half B includes the slot-7 sample arriving with the decoding strobe itself.
    always_comb begin
        strobe_ok = enable & slot_strobe;
        bit_end   = strobe_ok & (slot_q == 3'd7) & (state_q != S_IDLE);
        b_sum     = {1'b0, cnt_b_q} + {3'b000, curbit};
        a_mod     = ({1'b0, cnt_a_q} >= MOD_MIN_W);
        b_mod     = (b_sum >= MOD_MIN_W);
        case ({a_mod, b_mod})
            2'b10:   sym = SYM_ONE;
            2'b01:   sym = SYM_ZERO;
            2'b00:   sym = SYM_EOF;
            default: sym = SYM_COLL;
        endcase
        data_bit = (sym == SYM_ONE) || (sym == SYM_COLL);
    end

    always_ff @(negedge osc_clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a clean '1' is accepted as SOF; a collided SOF period is treated as noise.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (slot_strobe && curbit) state_d = S_SOF;
                end
                S_SOF: begin
                    if (bit_end) state_d = (sym == SYM_ONE) ? S_DATA : S_IDLE;
                end
                S_DATA: begin
                    if (bit_end && (sym == SYM_EOF)) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sof_start = 1'b0;
        sof_ok    = 1'b0;
        bit_take  = 1'b0;
        byte_done = 1'b0;
        eof_done  = 1'b0;
        if (enable) begin
            case (state_q)
                S_IDLE: sof_start = slot_strobe & curbit;
                S_SOF:  sof_ok    = bit_end & (sym == SYM_ONE);
                S_DATA: begin
                    if (bit_end) begin
                        if (sym == SYM_EOF) begin
                            eof_done = 1'b1;
                        end else begin
                            bit_take  = 1'b1;
                            byte_done = (grp_q == 4'd8);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge osc_clk or negedge nreset) begin
        if (!nreset) begin
            slot_q         <= '0;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            shift_q        <= '0;
            tail_q         <= '0;
            grp_q          <= '0;
            frame_active_q <= 1'b0;
            byte_valid_q   <= 1'b0;
            data_byte_q    <= '0;
            parity_bit_q   <= 1'b0;
            parity_err_q   <= 1'b0;
            frame_end_q    <= 1'b0;
            last_bits_q    <= '0;
        end else if (!enable) begin
            slot_q         <= '0;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            shift_q        <= '0;
            tail_q         <= '0;
            grp_q          <= '0;
            frame_active_q <= 1'b0;
            byte_valid_q   <= 1'b0;
            frame_end_q    <= 1'b0;
        end else begin
            byte_valid_q <= byte_done;
            frame_end_q  <= eof_done;

            if (sof_start) begin
                slot_q  <= 3'd1;
                cnt_a_q <= 3'd1;
                cnt_b_q <= 3'd0;
            end else if (strobe_ok && (state_q != S_IDLE)) begin
                slot_q <= slot_q + 3'd1;
                if (bit_end) begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                end else if (!slot_q[2]) begin
                    cnt_a_q <= cnt_a_q + {2'b00, curbit};
                end else begin
                    cnt_b_q <= cnt_b_q + {2'b00, curbit};
                end
            end

            if (sof_ok) begin
                frame_active_q <= 1'b1;
                grp_q          <= '0;
                shift_q        <= '0;
                tail_q         <= '0;
            end

            // The ninth bit of a group is parity and is never stored in the shifter.
            if (bit_take) begin
                if (byte_done) begin
                    grp_q        <= '0;
                    tail_q       <= '0;
                    data_byte_q  <= shift_q;
                    parity_bit_q <= data_bit;
                    parity_err_q <= ~(^{shift_q, data_bit});
                end else begin
                    grp_q   <= grp_q + 4'd1;
                    shift_q <= {data_bit, shift_q[7:1]};
                    tail_q  <= {tail_q[6:0], data_bit};
                end
            end

            // A trailing partial byte is shown in arrival order, earliest bit most significant.
            if (eof_done) begin
                frame_active_q <= 1'b0;
                last_bits_q    <= grp_q[2:0];
                grp_q          <= '0;
                if (grp_q[2:0] != 3'd0) data_byte_q <= tail_q;
            end
        end
    end

`ifdef HF14A_COLLISION_EN
    logic       coll_q;
    logic [6:0] coll_pos_q;
    logic [6:0] bit_idx_q;

    always_ff @(negedge osc_clk or negedge nreset) begin
        if (!nreset) begin
            coll_q     <= 1'b0;
            coll_pos_q <= '0;
            bit_idx_q  <= '0;
        end else if (!enable) begin
            bit_idx_q <= '0;
        end else begin
            if (sof_ok) begin
                coll_q     <= 1'b0;
                coll_pos_q <= '0;
                bit_idx_q  <= '0;
            end else if (bit_take) begin
                if (bit_idx_q != 7'd127) bit_idx_q <= bit_idx_q + 7'd1;
                if ((sym == SYM_COLL) && !coll_q) begin
                    coll_q     <= 1'b1;
                    coll_pos_q <= bit_idx_q;
                end
            end
        end
    end

    assign coll     = coll_q;
    assign coll_pos = coll_pos_q;
`else
    assign coll     = 1'b0;
    assign coll_pos = '0;
`endif

    assign frame_active = frame_active_q;
    assign byte_valid   = byte_valid_q;
    assign data_byte    = data_byte_q;
    assign parity_bit   = parity_bit_q;
    assign parity_err   = parity_err_q;
    assign frame_end    = frame_end_q;
    assign last_bits    = last_bits_q;

endmodule

// File: tb/tb_hf_14a_tag_frame_decoder.sv
// Bench for hf_14a_tag_frame_decoder: symbol-level frame model plus per-cycle pulse checker.
`timescale 1ns/1ps

module tb_hf_14a_tag_frame_decoder;

    localparam int K_SOF    = 0;
    localparam int K_ONE    = 1;
    localparam int K_ZERO   = 2;
    localparam int K_EOF    = 3;
    localparam int K_COLL   = 4;
    localparam int K_SOFBAD = 5;

    logic       osc_clk = 1'b1;
    logic       nreset = 1'b0;
    logic       enable = 1'b0;
    logic       slot_strobe = 1'b0;
    logic       curbit = 1'b0;
    logic       frame_active;
    logic       byte_valid;
    logic [7:0] data_byte;
    logic       parity_bit;
    logic       parity_err;
    logic       frame_end;
    logic [2:0] last_bits;
    logic       coll;
    logic [6:0] coll_pos;

    hf_14a_tag_frame_decoder #(.MOD_MIN(2)) dut (
        .osc_clk     (osc_clk),
        .nreset      (nreset),
        .enable      (enable),
        .slot_strobe (slot_strobe),
        .curbit      (curbit),
        .frame_active(frame_active),
        .byte_valid  (byte_valid),
        .data_byte   (data_byte),
        .parity_bit  (parity_bit),
        .parity_err  (parity_err),
        .frame_end   (frame_end),
        .last_bits   (last_bits),
        .coll        (coll),
        .coll_pos    (coll_pos)
    );

    always #5 osc_clk = ~osc_clk;

    typedef struct {
        time        t;
        bit         is_fe;
        logic [7:0] data;
        bit         par;
        bit         perr;
        logic [2:0] last;
        bit         coll;
        logic [6:0] cpos;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    // model state
    bit         m_grp[$];
    int         m_bidx = 0;
    bit         m_coll = 0;
    int         m_cpos = 0;
    logic [7:0] m_held = 8'h00;

    // observations captured by the checker
    int         bv_cnt = 0;
    int         fe_cnt = 0;
    time        bv_time = 0;
    time        fe_time = 0;
    logic [7:0] last_bv_data = 8'h00;
    logic       last_bv_perr = 1'b0;
    logic [2:0] last_lb = 3'd0;
    bit         fa_seen = 0;

    int pv = 0;
    logic [3:0] mod_pats   [4] = '{4'b1111, 4'b0011, 4'b1010, 4'b0110};
    logic [3:0] unmod_pats [4] = '{4'b0000, 4'b0001, 4'b1000, 4'b0100};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    task automatic m_sof();
        m_grp.delete();
        m_bidx = 0;
        m_coll = 0;
        m_cpos = 0;
    endtask

    task automatic m_abort();
        m_grp.delete();
    endtask

    task automatic m_bit(input bit b, input bit is_coll, input time t);
        ev_t ev;
        logic [7:0] d;
        if (is_coll && !m_coll) begin
            m_coll = 1;
            m_cpos = m_bidx;
        end
        if (m_bidx < 127) m_bidx++;
        m_grp.push_back(b);
        if (m_grp.size() == 9) begin
            d = '0;
            for (int i = 0; i < 8; i++) d[i] = m_grp[i];
            ev.t     = t;
            ev.is_fe = 0;
            ev.data  = d;
            ev.par   = m_grp[8];
            ev.perr  = ((($countones(d) + int'(m_grp[8])) % 2) == 0);
            ev.last  = '0;
            ev.coll  = 0;
            ev.cpos  = '0;
            exp_q.push_back(ev);
            m_held = d;
            m_grp.delete();
        end
    endtask

    task automatic m_eof(input time t);
        ev_t ev;
        logic [7:0] d;
        int n;
        n = m_grp.size() % 8;
        if (n != 0) begin
            d = '0;
            for (int i = 0; i < n; i++) d = {d[6:0], m_grp[i]};
            m_held = d;
        end
        ev.t     = t;
        ev.is_fe = 1;
        ev.data  = m_held;
        ev.par   = 0;
        ev.perr  = 0;
        ev.last  = 3'(n);
`ifdef HF14A_COLLISION_EN
        ev.coll  = m_coll;
        ev.cpos  = 7'(m_cpos);
`else
        ev.coll  = 0;
        ev.cpos  = '0;
`endif
        exp_q.push_back(ev);
        m_grp.delete();
    endtask

    task automatic model_sym(input int kind, input time t);
        case (kind)
            K_SOF:  m_sof();
            K_ONE:  m_bit(1'b1, 1'b0, t);
            K_ZERO: m_bit(1'b0, 1'b0, t);
            K_COLL: m_bit(1'b1, 1'b1, t);
            K_EOF:  m_eof(t);
            default: ;
        endcase
    endtask

    task automatic raw_slots(input int n, input bit v);
        for (int k = 0; k < n; k++) begin
            @(posedge osc_clk);
            slot_strobe = 1'b1;
            curbit = v;
            @(posedge osc_clk);
            slot_strobe = 1'b0;
            curbit = 1'b0;
            repeat (14) @(posedge osc_clk);
        end
    endtask

    task automatic send_sym(input int kind);
        logic [3:0] a, b;
        logic [7:0] pat;
        time t;
        a = unmod_pats[pv % 4];
        b = unmod_pats[(pv + 1) % 4];
        case (kind)
            K_ONE:    a = mod_pats[pv % 4];
            K_ZERO:   b = mod_pats[pv % 4];
            K_COLL:   begin a = mod_pats[pv % 4]; b = mod_pats[(pv + 1) % 4]; end
            K_SOF:    a = 4'b1111;
            K_SOFBAD: begin a = 4'b0001; b = 4'b0000; end
            default: ;
        endcase
        pv++;
        pat = {b, a};
        for (int i = 0; i < 8; i++) begin
            @(posedge osc_clk);
            slot_strobe = 1'b1;
            curbit = pat[i];
            t = $time;
            if (i == 7) model_sym(kind, t + 10);
            @(posedge osc_clk);
            slot_strobe = 1'b0;
            curbit = 1'b0;
            repeat (14) @(posedge osc_clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        send_sym(K_SOF);
        for (int i = 0; i < n; i++) send_sym(bits[i] ? K_ONE : K_ZERO);
        send_sym(K_EOF);
    endtask

    // per-cycle compare against the model's expected pulses
    always @(posedge osc_clk) begin
        ev_t ev;
        if (frame_active === 1'b1) fa_seen = 1;
        while (exp_q.size() > 0 && exp_q[0].t < $time) begin
            ev = exp_q.pop_front();
            chk("missed_pulse", 32'(ev.t), 32'($time));
        end
        if (nreset === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].t == $time) begin
                ev = exp_q.pop_front();
                if (ev.is_fe) begin
                    chk("frame_end", frame_end, 1);
                    chk("fe_byte_valid", byte_valid, 0);
                    chk("fe_last_bits", last_bits, ev.last);
                    chk("fe_data_byte", data_byte, ev.data);
                    chk("fe_frame_active", frame_active, 0);
                    chk("fe_coll", coll, ev.coll);
                    chk("fe_coll_pos", coll_pos, ev.cpos);
                    fe_time = $time;
                    last_lb = last_bits;
                    fe_cnt++;
                end else begin
                    chk("byte_valid", byte_valid, 1);
                    chk("bv_frame_end", frame_end, 0);
                    chk("bv_data_byte", data_byte, ev.data);
                    chk("bv_parity_bit", parity_bit, ev.par);
                    chk("bv_parity_err", parity_err, ev.perr);
                    chk("bv_frame_active", frame_active, 1);
                    bv_time = $time;
                    last_bv_data = data_byte;
                    last_bv_perr = parity_err;
                    bv_cnt++;
                end
            end else begin
                chk("no_pulse", {30'd0, byte_valid, frame_end}, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge osc_clk);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_data_byte", data_byte, 0);
        chk("rst_parity_bit", parity_bit, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_last_bits", last_bits, 0);
        chk("rst_coll", coll, 0);
        chk("rst_coll_pos", coll_pos, 0);
        @(posedge osc_clk);
        nreset = 1'b1;
        enable = 1'b1;
        raw_slots(2, 1'b0);

        // byte 0x04 with correct parity 0, then EOF 128 clocks after byte_valid
        send_sym(K_SOF);
        chk("sof_frame_active", frame_active, 1);
        for (int i = 0; i < 9; i++) send_sym(i == 2 ? K_ONE : K_ZERO);
        send_sym(K_EOF);
        chk("t1_data", last_bv_data, 8'h04);
        chk("t1_perr", last_bv_perr, 0);
        chk("t1_spacing", 32'(fe_time - bv_time), 1280);
        chk("t1_last_bits", last_lb, 0);

        // back-to-back: same byte with parity 1
        send_frame(32'h0000_0104, 9);
        chk("t2_perr", last_bv_perr, 1);
        chk("t2_data", last_bv_data, 8'h04);

        // ACK: 4 bits 1,0,1,0
        send_frame(32'h0000_0005, 4);
        chk("t3_bv_cnt", bv_cnt, 2);
        chk("t3_last_bits", last_lb, 4);
        chk("t3_nibble", data_byte[3:0], 4'hA);

        // lone modulated slot: SOF rejected
        fa_seen = 0;
        send_sym(K_SOFBAD);
        raw_slots(4, 1'b0);
        chk("t4_fa_seen", fa_seen, 0);
        chk("t4_fe_cnt", fe_cnt, 3);

        // collision on bit 3: decoded as 1 -> 0x0D, odd parity 0
        send_sym(K_SOF);
        send_sym(K_ONE);
        send_sym(K_ZERO);
        send_sym(K_ONE);
        send_sym(K_COLL);
        for (int i = 0; i < 5; i++) send_sym(K_ZERO);
        send_sym(K_EOF);
        chk("t5_data", last_bv_data, 8'h0D);
        chk("t5_perr", last_bv_perr, 0);
`ifdef HF14A_COLLISION_EN
        chk("t5_coll", coll, 1);
        chk("t5_coll_pos", coll_pos, 3);
`else
        chk("t5_coll", coll, 0);
        chk("t5_coll_pos", coll_pos, 0);
`endif

        // two bytes (0xA5 good parity, 0x3C bad parity) plus 3 trailing bits 1,1,0
        send_frame({11'd0, 3'b011, 9'h03C, 9'h1A5}, 21);
        chk("t6_last_bits", last_lb, 3);
        chk("t6_partial", data_byte, 8'h06);
        chk("t6_perr", last_bv_perr, 1);

        // 8 bits then EOF: parity lost, byte dropped, data_byte holds
        send_frame(32'h0000_00FF, 8);
        chk("t7_last_bits", last_lb, 0);
        chk("t7_held", data_byte, 8'h06);

        // enable dropped mid-byte, strobes ignored while low
        send_sym(K_SOF);
        send_sym(K_ONE);
        send_sym(K_ONE);
        send_sym(K_ZERO);
        @(posedge osc_clk);
        enable = 1'b0;
        m_abort();
        repeat (3) @(posedge osc_clk);
        chk("dis_frame_active", frame_active, 0);
        raw_slots(2, 1'b1);
        chk("dis_frame_active2", frame_active, 0);
        @(posedge osc_clk);
        enable = 1'b1;
        raw_slots(2, 1'b0);

        // async reset mid-frame
        send_sym(K_SOF);
        send_sym(K_ZERO);
        send_sym(K_ONE);
        chk("pre_rst_frame_active", frame_active, 1);
        @(posedge osc_clk);
        nreset = 1'b0;
        m_abort();
        m_held = 8'h00;
        repeat (2) @(posedge osc_clk);
        chk("rst2_frame_active", frame_active, 0);
        chk("rst2_data_byte", data_byte, 0);
        chk("rst2_last_bits", last_bits, 0);
        @(posedge osc_clk);
        nreset = 1'b1;
        raw_slots(2, 1'b0);

        // clean frame afterwards: 0x5A with odd parity 1
        send_frame(32'h0000_015A, 9);
        raw_slots(2, 1'b0);
        chk("t8_data", last_bv_data, 8'h5A);
        chk("t8_perr", last_bv_perr, 0);

        chk("pending_events", exp_q.size(), 0);
        chk("bv_total", bv_cnt, 6);
        chk("fe_total", fe_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
